// File: rtl/sweep_sequencer.sv
// Triangle-sweep controller for a 4-bit up/down counter.
// It steps the counter lo -> hi -> lo for a programmed number of passes.
module sweep_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_load,
    output logic              cnt_enable,
    output logic              cnt_up,
    output logic [WIDTH-1:0]  cnt_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  lo_r;
    logic [WIDTH-1:0]  hi_r;
    logic [PASS_W-1:0] passes_r;

    // Turn points are detected one step early, since the counter moves on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            passes_r <= '0;
            pass_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (lo < hi && passes != '0) begin
                                lo_r     <= lo;
                                hi_r     <= hi;
                                passes_r <= passes;
                                pass_cnt <= '0;
                                state    <= LOAD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: state <= UP;
                    UP: begin
                        if (cnt_q == hi_r - WIDTH'(1))
                            state <= DOWN;
                    end
                    DOWN: begin
                        if (cnt_q == lo_r + WIDTH'(1)) begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                            if (pass_cnt + PASS_W'(1) == passes_r)
                                state <= DONE;
                            else
                                state <= UP;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        cnt_up     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                cnt_load = 1'b1;
                busy     = 1'b1;
            end
            UP: begin
                cnt_enable = 1'b1;
                cnt_up     = 1'b1;
                busy       = 1'b1;
            end
            DOWN: begin
                cnt_enable = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign cnt_data = lo_r;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer with a behavioural up/down counter in the loop.
// Expected done/err pulses are queued at stimulus time and checked by an independent monitor.
module tb_sweep_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] passes;
    logic [3:0] cnt_q;
    logic       cnt_load;
    logic       cnt_enable;
    logic       cnt_up;
    logic [3:0] cnt_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pass_cnt;

    typedef struct {
        bit is_err;
        int pass_cnt;
        int cycle;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pass = 0;
    bit   load_seen = 0;

    sweep_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .lo         (lo),
        .hi         (hi),
        .passes     (passes),
        .cnt_q      (cnt_q),
        .cnt_load   (cnt_load),
        .cnt_enable (cnt_enable),
        .cnt_up     (cnt_up),
        .cnt_data   (cnt_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pass_cnt   (pass_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the external counter that the sequencer drives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (cnt_load)
            cnt_q <= cnt_data;
        else if (cnt_enable)
            cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_load)
            load_seen <= 1'b1;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (done || err)) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_output("pulse_is_err", int'(err), int'(e.is_err));
                check_output("pulse_pass_cnt", int'(pass_cnt), e.pass_cnt);
                check_output("pulse_cycle", cyc, e.cycle);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the start edge E0.
    task automatic apply_stimulus(input int l, input int h, input int p, input bit ok);
        exp_t e;
        int   e0;
        lo     = 4'(l);
        hi     = 4'(h);
        passes = 4'(p);
        start  = 1'b1;
        e0 = cyc + 1;
        if (ok) begin
            e.is_err   = 1'b0;
            e.pass_cnt = p;
            e.cycle    = e0 + 1 + p * 2 * (h - l);
        end else begin
            e.is_err   = 1'b1;
            e.pass_cnt = last_pass;
            e.cycle    = e0;
        end
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy && !done)
                return;
            @(negedge clk);
        end
        check_output("idle_timeout", 1, 0);
    endtask

    int trace1[13] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
    int trace2[7]  = '{7, 8, 7, 8, 7, 8, 7};

    initial begin
        bit found;
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        lo     = '0;
        hi     = '0;
        passes = '0;

        @(negedge clk);
        check_output("rst_cnt_load", int'(cnt_load), 0);
        check_output("rst_cnt_enable", int'(cnt_enable), 0);
        check_output("rst_cnt_up", int'(cnt_up), 0);
        check_output("rst_cnt_data", int'(cnt_data), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_err", int'(err), 0);
        check_output("rst_pass_cnt", int'(pass_cnt), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] sweep lo=3 hi=6 passes=2");
        apply_stimulus(3, 6, 2, 1'b1);
        check_output("t1_load", int'(cnt_load), 1);
        check_output("t1_load_data", int'(cnt_data), 3);
        check_output("t1_busy", int'(busy), 1);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check_output($sformatf("t1_cnt_q[%0d]", k), int'(cnt_q), trace1[k]);
        end
        @(negedge clk);
        check_output("t1_busy_after", int'(busy), 0);
        check_output("t1_pass_cnt", int'(pass_cnt), 2);
        last_pass = 2;

        $display("[TB] sweep lo=7 hi=8 passes=3");
        apply_stimulus(7, 8, 3, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check_output($sformatf("t2_cnt_q[%0d]", k), int'(cnt_q), trace2[k]);
        end
        wait_idle();
        check_output("t2_pass_cnt", int'(pass_cnt), 3);
        last_pass = 3;

        $display("[TB] rejected starts");
        load_seen = 1'b0;
        apply_stimulus(5, 5, 1, 1'b0);
        check_output("err1_busy", int'(busy), 0);
        apply_stimulus(9, 2, 1, 1'b0);
        check_output("err2_busy", int'(busy), 0);
        apply_stimulus(2, 9, 0, 1'b0);
        check_output("err3_busy", int'(busy), 0);
        @(negedge clk);
        check_output("err_no_load", int'(load_seen), 0);
        check_output("err_pass_cnt_kept", int'(pass_cnt), 3);

        $display("[TB] abort during lo=0 hi=15 sweep");
        apply_stimulus(0, 15, 1, 1'b1);
        void'(sb_q.pop_back());
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_q == 4'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("abort_reach_10", int'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_enable", int'(cnt_enable), 0);
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_cnt_q", int'(cnt_q), 11);
        check_output("abort_pass_cnt", int'(pass_cnt), 0);
        repeat (3) @(negedge clk);
        check_output("abort_cnt_q_frozen", int'(cnt_q), 11);
        last_pass = 0;

        $display("[TB] start ignored during active sweep");
        apply_stimulus(1, 4, 1, 1'b1);
        repeat (2) @(negedge clk);
        lo     = 4'd0;
        hi     = 4'd9;
        passes = 4'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check_output("ign_pass_cnt", int'(pass_cnt), 1);
        last_pass = 1;

        $display("[TB] reset while in DOWN");
        apply_stimulus(3, 6, 1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && cnt_enable && !cnt_up) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("rst_reach_down", int'(found), 1);
        #1 reset = 1'b0;
        sb_q.delete();
        #1;
        check_output("midrst_cnt_enable", int'(cnt_enable), 0);
        check_output("midrst_cnt_load", int'(cnt_load), 0);
        check_output("midrst_busy", int'(busy), 0);
        check_output("midrst_pass_cnt", int'(pass_cnt), 0);
        check_output("midrst_cnt_data", int'(cnt_data), 0);
        @(negedge clk);
        reset = 1'b1;
        last_pass = 0;
        @(negedge clk);
        apply_stimulus(2, 3, 1, 1'b1);
        wait_idle();
        check_output("post_rst_pass_cnt", int'(pass_cnt), 1);

        repeat (3) @(negedge clk);
        check_output("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
